// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch / sequencing controller.
// Walks each instruction through FETCH -> DECODE -> (EXEC | MEM [-> WB]),
// drives the memory port, the register-file/PSR write strobes and a one-cycle
// PC advance pulse, and counts retired instructions.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | read memory at PC, latch IR when mem_ready
//   DECODE | classify IR: LOAD/STOR -> MEM, everything else -> EXEC
//   EXEC   | single-cycle ALU/compare/branch/jump, PCen pulse
//   MEM    | data access at addr_reg, held until mem_ready
//   WB     | write loaded word back to the register file, PCen pulse
module instr_fetch_ctrl (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] PC,
    input  logic [15:0] addr_reg,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] IR,
    output logic [3:0]  Opcode,
    output logic [3:0]  CondRlink,
    output logic [3:0]  OpcodeExt_dispHi,
    output logic [3:0]  dispLo,
    output logic        PCen,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        psr_we,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir_q;
    logic [15:0] retired_q;
    // Loaded word is captured for observability; the register file takes its
    // write-back data straight from mem_rdata via wb_sel.
    logic [15:0] ld_data_unused;

    logic is_load;
    logic is_stor;
    logic is_nowb;
    logic is_cmp;

    assign is_load = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b0000);
    assign is_stor = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b0100);
    assign is_nowb = (ir_q[15:12] == 4'b0100) || (ir_q[15:12] == 4'b1100);
    assign is_cmp  = (ir_q[15:12] == 4'b1011) ||
                     ((ir_q[15:12] == 4'b0000) && (ir_q[7:4] == 4'b1011));

    // State register; reset returns to FETCH regardless of anything in flight.
    always_ff @(posedge clk) begin
        if (!Reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Instruction register: only a completed fetch may update it.
    always_ff @(posedge clk) begin
        if (!Reset)
            ir_q <= 16'h0000;
        else if ((state == FETCH) && mem_ready)
            ir_q <= mem_rdata;
    end

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!Reset)
            retired_q <= 16'h0000;
        else
            retired_q <= retired_q + {15'd0, PCen};
    end

    // Load data capture on the completing MEM cycle of a LOAD.
    always_ff @(posedge clk) begin
        if (!Reset)
            ld_data_unused <= 16'h0000;
        else if ((state == MEM) && is_load && mem_ready)
            ld_data_unused <= mem_rdata;
    end

    // Next-state and control outputs; everything is forced idle while Reset is low.
    always_comb begin
        state_nxt = state;
        mem_addr  = PC;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        PCen      = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        psr_we    = 1'b0;
        if (Reset) begin
            case (state)
                FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready)
                        state_nxt = DECODE;
                end
                DECODE: begin
                    state_nxt = (is_load || is_stor) ? MEM : EXEC;
                end
                EXEC: begin
                    PCen      = 1'b1;
                    state_nxt = FETCH;
                    if (is_nowb) begin
                        reg_we = 1'b0;
                        psr_we = 1'b0;
                    end else if (is_cmp) begin
                        psr_we = 1'b1;
                    end else begin
                        reg_we = 1'b1;
                        psr_we = 1'b1;
                    end
                end
                MEM: begin
                    mem_addr = addr_reg;
                    mem_re   = is_load;
                    mem_we   = is_stor;
                    if (mem_ready) begin
                        if (is_load) begin
                            state_nxt = WB;
                        end else begin
                            PCen      = 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                end
                WB: begin
                    reg_we    = 1'b1;
                    wb_sel    = 1'b1;
                    PCen      = 1'b1;
                    state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    assign IR               = Reset ? ir_q : 16'h0000;
    assign retired          = Reset ? retired_q : 16'h0000;
    assign Opcode           = IR[15:12];
    assign CondRlink        = IR[11:8];
    assign OpcodeExt_dispHi = IR[7:4];
    assign dispLo           = IR[3:0];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl. A transaction-level model expands
// each instruction into its expected per-cycle output trace from the
// instruction class and the chosen memory wait counts.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] PC;
    logic [15:0] addr_reg;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] IR;
    logic [3:0]  Opcode;
    logic [3:0]  CondRlink;
    logic [3:0]  OpcodeExt_dispHi;
    logic [3:0]  dispLo;
    logic        PCen;
    logic        reg_we;
    logic        wb_sel;
    logic        psr_we;
    logic [15:0] retired;

    instr_fetch_ctrl dut (
        .clk              (clk),
        .Reset            (Reset),
        .PC               (PC),
        .addr_reg         (addr_reg),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .mem_addr         (mem_addr),
        .mem_re           (mem_re),
        .mem_we           (mem_we),
        .IR               (IR),
        .Opcode           (Opcode),
        .CondRlink        (CondRlink),
        .OpcodeExt_dispHi (OpcodeExt_dispHi),
        .dispLo           (dispLo),
        .PCen             (PCen),
        .reg_we           (reg_we),
        .wb_sel           (wb_sel),
        .psr_we           (psr_we),
        .retired          (retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: architecturally visible IR and retired count.
    logic [15:0] m_ir;
    logic [15:0] m_ret;

    // Control bits are packed {mem_re, mem_we, PCen, reg_we, wb_sel, psr_we}.
    localparam logic [5:0] C_FETCH = 6'b100000;
    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_WB    = 6'b001110;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle out of reset: drive inputs at negedge, check 1ns later.
    task automatic cyc(input logic rdy, input logic [15:0] rdata, input logic use_areg,
                       input logic [5:0] e_ctl, input string tag);
        logic [15:0] e_addr;
        @(negedge clk);
        Reset     = 1'b1;
        PC        = 16'($urandom);
        addr_reg  = 16'($urandom);
        mem_ready = rdy;
        mem_rdata = rdata;
        e_addr    = use_areg ? addr_reg : PC;
        #1;
        chk({tag, ".ctl"}, {26'd0, mem_re, mem_we, PCen, reg_we, wb_sel, psr_we}, {26'd0, e_ctl});
        chk({tag, ".addr"}, {16'd0, mem_addr}, {16'd0, e_addr});
        chk({tag, ".ir"}, {16'd0, IR}, {16'd0, m_ir});
        chk({tag, ".fields"}, {16'd0, Opcode, CondRlink, OpcodeExt_dispHi, dispLo}, {16'd0, m_ir});
        chk({tag, ".retired"}, {16'd0, retired}, {16'd0, m_ret});
    endtask

    // One cycle with Reset held low: everything idle, mem_addr follows PC.
    task automatic rst_cyc(input string tag);
        @(negedge clk);
        Reset     = 1'b0;
        PC        = 16'($urandom);
        addr_reg  = 16'($urandom);
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        chk({tag, ".ctl"}, {26'd0, mem_re, mem_we, PCen, reg_we, wb_sel, psr_we}, 32'd0);
        chk({tag, ".addr"}, {16'd0, mem_addr}, {16'd0, PC});
        chk({tag, ".ir"}, {16'd0, IR}, 32'd0);
        chk({tag, ".retired"}, {16'd0, retired}, 32'd0);
        m_ir  = 16'h0000;
        m_ret = 16'h0000;
    endtask

    // Expected trace of one full instruction, given fetch and memory wait counts.
    task automatic exec_instr(input logic [15:0] instr, input int fw, input int mw);
        logic [3:0] op;
        logic [3:0] ext;
        logic       ld;
        logic [5:0] e;
        op  = instr[15:12];
        ext = instr[7:4];
        for (int i = 0; i < fw; i++)
            cyc(1'b0, 16'($urandom), 1'b0, C_FETCH, "fetch_wait");
        cyc(1'b1, instr, 1'b0, C_FETCH, "fetch");
        m_ir = instr;
        cyc(1'($urandom), 16'($urandom), 1'b0, C_IDLE, "decode");
        if (op == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
            ld = (ext == 4'h0);
            for (int i = 0; i < mw; i++)
                cyc(1'b0, 16'($urandom), 1'b1, {ld, ~ld, 4'b0000}, "mem_wait");
            cyc(1'b1, 16'($urandom), 1'b1, {ld, ~ld, ~ld, 3'b000}, "mem");
            if (ld)
                cyc(1'($urandom), 16'($urandom), 1'b0, C_WB, "wb");
            m_ret = m_ret + 16'd1;
        end else begin
            if (op == 4'h4 || op == 4'hC)
                e = 6'b001000;
            else if (op == 4'hB || (op == 4'h0 && ext == 4'hB))
                e = 6'b001001;
            else
                e = 6'b001101;
            cyc(1'($urandom), 16'($urandom), 1'b0, e, "exec");
            m_ret = m_ret + 16'd1;
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 5))
            0: w[15:4] = {4'h4, w[11:8], 4'h0};
            1: w[15:4] = {4'h4, w[11:8], 4'h4};
            2: w[15:12] = 4'hB;
            3: w[15:4] = {4'h0, w[11:8], 4'hB};
            4: w[15:12] = 4'hC;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        Reset     = 1'b0;
        PC        = 16'h0000;
        addr_reg  = 16'h0000;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
        m_ir      = 16'h0000;
        m_ret     = 16'h0000;

        rst_cyc("reset0");
        rst_cyc("reset1");

        exec_instr(16'h0521, 0, 0);     // ALU
        exec_instr(16'h4304, 1, 2);     // LOAD with two wait cycles in MEM
        exec_instr(16'h4344, 0, 1);     // STOR
        exec_instr(16'h4EC5, 2, 0);     // JCOND UC
        exec_instr(16'hC0FE, 0, 0);     // BCOND
        exec_instr(16'hB123, 0, 0);     // CMPI
        exec_instr(16'h02B5, 0, 0);     // CMP
        exec_instr(16'h4304, 0, 0);     // LOAD, minimum latency

        // Reset in the middle of a store: no pulse, state back to FETCH.
        cyc(1'b1, 16'h4344, 1'b0, C_FETCH, "abort.fetch");
        m_ir = 16'h4344;
        cyc(1'b0, 16'($urandom), 1'b0, C_IDLE, "abort.decode");
        cyc(1'b0, 16'($urandom), 1'b1, 6'b010000, "abort.mem");
        rst_cyc("abort.reset");
        cyc(1'b0, 16'($urandom), 1'b0, C_FETCH, "abort.refetch");
        exec_instr(16'h1234, 0, 0);

        // Retired counter wrap: deposit 0xFFFF while idling in FETCH.
        @(negedge clk);
        mem_ready = 1'b0;
        force dut.retired_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.retired_q;
        m_ret = 16'hFFFF;
        exec_instr(16'h5123, 0, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("wrap.retired", {16'd0, retired}, 32'd0);

        for (int n = 0; n < 300; n++)
            exec_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port PC, input, 16 bits: current program counter from the PC control stage.
REQ-004 SHALL have port addr_reg, input, 16 bits: register-file read of IR[3:0], used as the load/store address.
REQ-005 SHALL have port mem_rdata, input, 16 bits: memory read data.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory access complete this cycle.
REQ-007 SHALL have port mem_addr, output, 16 bits: memory address.
REQ-008 SHALL have port mem_re, output, 1 bit: memory read request.
REQ-009 SHALL have port mem_we, output, 1 bit: memory write request.
REQ-010 SHALL have port IR, output, 16 bits: latched instruction.
REQ-011 SHALL have ports Opcode, CondRlink, OpcodeExt_dispHi and dispLo, outputs, 4 bits each, equal to IR[15:12], IR[11:8], IR[7:4] and IR[3:0].
REQ-012 SHALL have port PCen, output, 1 bit: one-cycle pulse that advances the PC stage.
REQ-013 SHALL have port reg_we, output, 1 bit: register-file write enable.
REQ-014 SHALL have port wb_sel, output, 1 bit: write-back source select, 1 = mem_rdata, 0 = ALU.
REQ-015 SHALL have port psr_we, output, 1 bit: PSR update enable.
REQ-016 SHALL have port retired, output, 16 bits: count of retired instructions.

Function
REQ-017 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM and WB.
REQ-018 In FETCH, the block SHALL drive mem_addr=PC and mem_re=1, latch IR<=mem_rdata, and move to DECODE on the first cycle with mem_ready=1; otherwise it SHALL stay in FETCH.
REQ-019 In DECODE, the block SHALL classify IR:
- LOAD (Opcode=0100, ext=0000) and STOR (Opcode=0100, ext=0100) go to MEM.
- All other instructions go to EXEC.
REQ-020 EXEC SHALL last 1 cycle: PCen=1 and next state FETCH.
REQ-021 In EXEC for Opcode 0100 with ext other than 0000/0100, or Opcode 1100, the block SHALL hold reg_we=0 and psr_we=0.
REQ-022 In EXEC for compare instructions (Opcode=1011, or Opcode=0000 with ext=1011), the block SHALL assert psr_we=1 and hold reg_we=0.
REQ-023 In EXEC for all other opcodes, the block SHALL assert reg_we=1, psr_we=1 and wb_sel=0.
REQ-024 In MEM, the block SHALL drive mem_addr=addr_reg, with mem_re=1 for LOAD or mem_we=1 for STOR, held until mem_ready=1.
REQ-025 When MEM sees mem_ready=1 on a STOR, the block SHALL pulse PCen=1 and go to FETCH.
REQ-026 When MEM sees mem_ready=1 on a LOAD, the block SHALL capture mem_rdata internally and go to WB.
REQ-027 WB SHALL last 1 cycle: reg_we=1, wb_sel=1, psr_we=0, PCen=1, next state FETCH.
REQ-028 PCen SHALL be high for exactly one cycle per instruction and never in FETCH or DECODE, so the PC is updated at the edge ending that cycle and the next FETCH uses the new PC.
REQ-029 Minimum latency with mem_ready tied high SHALL be 3 cycles for ALU/branch/jump instructions, 3 for STOR and 4 for LOAD.
REQ-030 retired SHALL increment by 1 on every cycle with PCen=1 and wrap from 0xFFFF to 0x0000.
REQ-031 mem_re and mem_we SHALL never both be 1.
REQ-032 Outside the states named above, mem_re, mem_we, reg_we, psr_we, wb_sel and PCen SHALL be 0, and mem_addr SHALL equal PC.
REQ-033 IR SHALL change only in FETCH on a mem_ready cycle.
REQ-034 If mem_ready is held low indefinitely, the block SHALL remain in its current state with its outputs stable.

Reset
REQ-035 When Reset=0 at a rising edge, the next state SHALL be FETCH and IR, retired and the captured load data SHALL be 0x0000, taking precedence over every other event.
REQ-036 While in reset, all outputs SHALL be 0, except that Opcode, CondRlink, OpcodeExt_dispHi and dispLo follow IR=0 and mem_addr follows REQ-032.
REQ-037 Reset asserted mid-MEM or mid-WB SHALL abort the instruction with no PCen, reg_we or mem_we pulse after the reset edge.

Verification
REQ-038 ALU case: mem_ready=1, PC=0x0010, mem_rdata=0x0521 -> IR=0x0521 after cycle 1; PCen, reg_we and psr_we high in cycle 3 only; retired=1.
REQ-039 Load case: mem_rdata=0x4304 (LOAD), addr_reg=0x0200, mem_ready low 2 cycles in MEM -> mem_addr=0x0200 and mem_re=1 for 3 cycles; WB shows reg_we=1, wb_sel=1, PCen=1; total 6 cycles.
REQ-040 Store case: mem_rdata=0x4344 (STOR) -> mem_we=1 in MEM, PCen in the same cycle, reg_we never asserted.
REQ-041 Jump/branch case: IR=0x4EC5 (JCOND UC), then IR=0xC0FE (BCOND) -> PCen in EXEC, reg_we=0 and psr_we=0 for both.
REQ-042 Wrap case: preload retired to 0xFFFF by executing 65535 ALU instructions, execute one more -> retired=0x0000.
REQ-043 Reset case: Reset=0 during MEM with mem_we=1 -> next cycle state FETCH, mem_we=0, IR=0x0000, retired=0, no PCen pulse.
